// File: rtl/alu_issue.sv
// Command-issue stage feeding a combinational ALU: queues (op, a, b) commands, registers operands, captures results.
// Optional macro ALU_ISSUE_ERRCHK_EN enables illegal-opcode flagging (res_err) and zeroing of res_data.
module alu_issue #(
   parameter int             DEPTH  = 4,
   parameter int             DATA_W = 8,
   parameter int             OP_W   = 4,
   parameter logic [OP_W-1:0] OP_MAX = 'hB
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [OP_W-1:0]              cmd_op,
   input  logic [DATA_W-1:0]            cmd_a,
   input  logic [DATA_W-1:0]            cmd_b,
   output logic [OP_W-1:0]              alu_op,
   output logic [DATA_W-1:0]            alu_a,
   output logic [DATA_W-1:0]            alu_b,
   input  logic [DATA_W:0]              alu_out,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic [DATA_W:0]              res_data,
   output logic [OP_W-1:0]              res_op,
   output logic                         res_err,
   output logic [$clog2(DEPTH):0]       count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      OUT
   } state_t;

   state_t state_q, state_d;

   logic [OP_W-1:0]   fifo_op_q [DEPTH];
   logic [OP_W-1:0]   fifo_op_d [DEPTH];
   logic [DATA_W-1:0] fifo_a_q  [DEPTH];
   logic [DATA_W-1:0] fifo_a_d  [DEPTH];
   logic [DATA_W-1:0] fifo_b_q  [DEPTH];
   logic [DATA_W-1:0] fifo_b_d  [DEPTH];

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [OP_W-1:0]   alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;

   logic              res_valid_q, res_valid_d;
   logic [DATA_W:0]   res_data_q, res_data_d;
   logic [OP_W-1:0]   res_op_q, res_op_d;

   logic              push;
   logic              pop;

`ifdef ALU_ISSUE_ERRCHK_EN
   logic              res_err_q, res_err_d;
`endif

   always_comb begin
      state_d     = state_q;
      alu_op_d    = alu_op_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_op_d    = res_op_q;
`ifdef ALU_ISSUE_ERRCHK_EN
      res_err_d   = res_err_q;
`endif
      pop         = 1'b0;
      // cmd_ready looks only at the registered count, so a full FIFO refuses pushes even when popping
      push        = cmd_valid && (count_q < FULL_CNT);

      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               state_d = EVAL;
            end
         end
         EVAL: begin
            res_valid_d = 1'b1;
            res_op_d    = alu_op_q;
`ifdef ALU_ISSUE_ERRCHK_EN
            if (alu_op_q > OP_MAX) begin
               res_err_d  = 1'b1;
               res_data_d = '0;
            end else begin
               res_err_d  = 1'b0;
               res_data_d = alu_out;
            end
`else
            res_data_d  = alu_out;
`endif
            state_d     = OUT;
         end
         OUT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  state_d = EVAL;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (pop) begin
         alu_op_d = fifo_op_q[rd_ptr_q];
         alu_a_d  = fifo_a_q[rd_ptr_q];
         alu_b_d  = fifo_b_q[rd_ptr_q];
      end
   end

   always_comb begin
      fifo_op_d = fifo_op_q;
      fifo_a_d  = fifo_a_q;
      fifo_b_d  = fifo_b_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push) begin
         fifo_op_d[wr_ptr_q] = cmd_op;
         fifo_a_d[wr_ptr_q]  = cmd_a;
         fifo_b_d[wr_ptr_q]  = cmd_b;
         wr_ptr_d            = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         alu_op_q    <= '0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_op_q    <= '0;
`ifdef ALU_ISSUE_ERRCHK_EN
         res_err_q   <= 1'b0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            fifo_op_q[i] <= '0;
            fifo_a_q[i]  <= '0;
            fifo_b_q[i]  <= '0;
         end
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         alu_op_q    <= alu_op_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_op_q    <= res_op_d;
`ifdef ALU_ISSUE_ERRCHK_EN
         res_err_q   <= res_err_d;
`endif
         fifo_op_q   <= fifo_op_d;
         fifo_a_q    <= fifo_a_d;
         fifo_b_q    <= fifo_b_d;
      end
   end

   assign cmd_ready = (count_q < FULL_CNT);
   assign count     = count_q;
   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_op    = res_op_q;
`ifdef ALU_ISSUE_ERRCHK_EN
   assign res_err   = res_err_q;
`else
   assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with an adder stub standing in for the ALU.
module tb_alu_issue;

   logic       clk;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic [3:0] alu_op;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [8:0] alu_out;
   logic       res_valid;
   logic       res_ready;
   logic [8:0] res_data;
   logic [3:0] res_op;
   logic       res_err;
   logic [2:0] count;

   int checks;
   int failures;

   alu_issue dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .alu_op    (alu_op),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_out   (alu_out),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_op    (res_op),
      .res_err   (res_err),
      .count     (count)
   );

   assign alu_out = {1'b0, alu_a} + {1'b0, alu_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'h1);
      checkOutput({tag, "_count"},     32'(count),     32'h0);
      checkOutput({tag, "_res_valid"}, 32'(res_valid), 32'h0);
      checkOutput({tag, "_res_data"},  32'(res_data),  32'h0);
      checkOutput({tag, "_res_op"},    32'(res_op),    32'h0);
      checkOutput({tag, "_res_err"},   32'(res_err),   32'h0);
      checkOutput({tag, "_alu_a"},     32'(alu_a),     32'h0);
      checkOutput({tag, "_alu_b"},     32'(alu_b),     32'h0);
      checkOutput({tag, "_alu_op"},    32'(alu_op),    32'h0);
   endtask

   initial begin
      logic [3:0] ops [5];
      logic [7:0] as  [5];
      logic [7:0] bs  [5];
      logic [8:0] exps[5];
      checks    = 0;
      failures  = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b0;
      #12;
      checkReset("rst");
      rst_n = 1'b1;

      // single command: push, pop, capture
      res_ready = 1'b1;
      applyStimulus(4'h0, 8'h6B, 8'hAA);
      stepCycle();
      cmd_valid = 1'b0;
      checkOutput("t1_count_push", 32'(count), 32'h1);
      checkOutput("t1_valid_n1", 32'(res_valid), 32'h0);
      stepCycle();
      checkOutput("t1_alu_a", 32'(alu_a), 32'h6B);
      checkOutput("t1_alu_b", 32'(alu_b), 32'hAA);
      checkOutput("t1_count_pop", 32'(count), 32'h0);
      checkOutput("t1_valid_n2", 32'(res_valid), 32'h0);
      stepCycle();
      checkOutput("t1_valid", 32'(res_valid), 32'h1);
      checkOutput("t1_data", 32'(res_data), 32'h115);
      checkOutput("t1_op", 32'(res_op), 32'h0);
      checkOutput("t1_err", 32'(res_err), 32'h0);
      stepCycle();
      checkOutput("t1_valid_clr", 32'(res_valid), 32'h0);

      // five back-to-back pushes with a stalled consumer: one lands in the ALU, four fill the FIFO
      ops  = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
      as   = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
      bs   = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      exps = '{9'h013, 9'h024, 9'h035, 9'h046, 9'h057};
      res_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(ops[i], as[i], bs[i]);
         stepCycle();
      end
      cmd_valid = 1'b0;
      checkOutput("t2_count_full", 32'(count), 32'h4);
      checkOutput("t2_cmd_ready", 32'(cmd_ready), 32'h0);
      checkOutput("t2_valid", 32'(res_valid), 32'h1);
      checkOutput("t2_data0", 32'(res_data), 32'h013);

      for (int i = 0; i < 5; i++) begin
         stepCycle();
         checkOutput("t5_hold_valid", 32'(res_valid), 32'h1);
         checkOutput("t5_hold_data", 32'(res_data), 32'h013);
         checkOutput("t5_hold_op", 32'(res_op), 32'h1);
         checkOutput("t5_hold_alu_a", 32'(alu_a), 32'h10);
         checkOutput("t5_hold_alu_b", 32'(alu_b), 32'h03);
         checkOutput("t5_hold_count", 32'(count), 32'h4);
      end

      // full FIFO: push refused while the result is consumed and the next head popped
      applyStimulus(4'h6, 8'h60, 8'h08);
      res_ready = 1'b1;
      stepCycle();
      cmd_valid = 1'b0;
      checkOutput("t3_count", 32'(count), 32'h3);
      checkOutput("t3_valid", 32'(res_valid), 32'h0);
      checkOutput("t3_alu_a", 32'(alu_a), 32'h20);

      for (int i = 1; i < 5; i++) begin
         stepCycle();
         checkOutput("t2_drain_valid", 32'(res_valid), 32'h1);
         checkOutput("t2_drain_data", 32'(res_data), 32'(exps[i]));
         checkOutput("t2_drain_op", 32'(res_op), 32'(ops[i]));
         checkOutput("t2_drain_count", 32'(count), 32'(4 - i));
         stepCycle();
         checkOutput("t2_drain_gap", 32'(res_valid), 32'h0);
      end
      for (int i = 0; i < 3; i++) begin
         stepCycle();
         checkOutput("t3_no_refused", 32'(res_valid), 32'h0);
         checkOutput("t2_count_empty", 32'(count), 32'h0);
      end

      // illegal opcode
      applyStimulus(4'hC, 8'hFF, 8'h01);
      stepCycle();
      cmd_valid = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("t4_valid", 32'(res_valid), 32'h1);
      checkOutput("t4_op", 32'(res_op), 32'hC);
`ifdef ALU_ISSUE_ERRCHK_EN
      checkOutput("t4_err", 32'(res_err), 32'h1);
      checkOutput("t4_data", 32'(res_data), 32'h000);
`else
      checkOutput("t4_err", 32'(res_err), 32'h0);
      checkOutput("t4_data", 32'(res_data), 32'h100);
`endif
      stepCycle();
      checkOutput("t4_valid_clr", 32'(res_valid), 32'h0);

      // reach EVAL with two commands queued, then reset
      res_ready = 1'b0;
      applyStimulus(4'h7, 8'h01, 8'h02);
      stepCycle();
      applyStimulus(4'h8, 8'h03, 8'h04);
      stepCycle();
      applyStimulus(4'h9, 8'h05, 8'h06);
      stepCycle();
      applyStimulus(4'hA, 8'h07, 8'h08);
      stepCycle();
      cmd_valid = 1'b0;
      checkOutput("t6_count_pre", 32'(count), 32'h3);
      res_ready = 1'b1;
      stepCycle();
      checkOutput("t6_count_eval", 32'(count), 32'h2);
      checkOutput("t6_alu_a_eval", 32'(alu_a), 32'h03);
      rst_n = 1'b0;
      #1;
      checkReset("t6_rst");
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         stepCycle();
         checkOutput("t6_no_stale_valid", 32'(res_valid), 32'h0);
         checkOutput("t6_no_stale_count", 32'(count), 32'h0);
         checkOutput("t6_no_stale_alu_a", 32'(alu_a), 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
